// File: rtl/mhrd_pkg.sv
// Shared definitions for the nibble-serial arithmetic datapath.
// The overflow helper works purely from the sign bits of the operands and the result.
package mhrd_pkg;

  localparam int NIBBLE_W = 4;
  localparam int WORD_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_seq_state_t;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder16_seq_adder4b.sv
// Existing 4-bit ripple adder cell that the sequential adder reuses once per nibble.
// It is purely combinational.
module ADDER4B (
  input  logic       carryIn,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [3:0] out,
  output logic       carryOut
);

  logic [4:0] w_sum;

  assign w_sum    = {1'b0, in1} + {1'b0, in2} + {4'b0000, carryIn};
  assign out      = w_sum[3:0];
  assign carryOut = w_sum[4];

endmodule

// File: rtl/adder16_seq.sv
// Nibble-serial adder/subtractor: one ADDER4B evaluated over NIBBLES cycles.
// Only the inter-nibble carry and the partial result cross clock edges.
module adder16_seq
  import mhrd_pkg::*;
#(
  parameter int NIBBLES = WORD_W / NIBBLE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         sub,
  input  logic                         carryIn,
  input  logic [NIBBLE_W*NIBBLES-1:0]  in1,
  input  logic [NIBBLE_W*NIBBLES-1:0]  in2,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  out,
  output logic                         carryOut,
  output logic                         overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  adder_seq_state_t r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_part;
  logic [W-1:0]     r_out;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;

  logic [NIBBLE_W-1:0] w_nib_a;
  logic [NIBBLE_W-1:0] w_nib_b;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic [W-1:0]        w_result;
  logic                w_last;

  // Select the active operand nibbles and merge the adder output into the partial result.
  always_comb begin
    w_nib_a  = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    w_nib_b  = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    w_result = r_part;
    w_result[r_idx*NIBBLE_W +: NIBBLE_W] = w_sum;
  end

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  ADDER4B u_adder4b (
    .carryIn  (r_carry),
    .in1      (w_nib_a),
    .in2      (w_nib_b),
    .out      (w_sum),
    .carryOut (w_cout)
  );

  // Control FSM and datapath registers; outputs only move on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1, so the caller's carry is replaced.
            r_a     <= in1;
            r_b     <= sub ? ~in2 : in2;
            r_carry <= sub ? 1'b1 : carryIn;
            r_part  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_part  <= w_result;
          r_carry <= w_cout;
          if (w_last) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_out   <= w_result;
            r_cout  <= w_cout;
            r_ovf   <= signed_ovf(r_a[W-1], r_b[W-1], w_sum[NIBBLE_W-1]);
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out      = r_out;
  assign carryOut = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_adder16_seq.sv
// Self-checking bench for adder16_seq: directed vector table, random ops against
// an arithmetic reference model, and handshake / reset corner sequences.
module tb_adder16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [15:0] hold_out = 16'h0000;

  always #5 clk = ~clk;

  adder16_seq #(.NIBBLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .carryIn  (cin),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .carryOut (cout),
    .overflow (ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        c;
    logic [15:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                       output logic [15:0] r, output logic co, output logic ov);
    int ua, ub, sa, sb, full, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      full = ua - ub;
      co   = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(c);
      co   = (full > 65535);
      sr   = sa + sb + int'(c);
    end
    r  = full[15:0];
    ov = (sr > 32767) || (sr < -32768);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c,
                        input logic [15:0] er, input logic eco, input logic eov);
    @(negedge clk);
    in1 = a; in2 = b; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom); sub = ~s; cin = ~c;
    chk({tag, " busy0"}, {30'd0, busy, done}, 32'd2);
    chk({tag, " hold"}, {16'd0, out}, {16'd0, hold_out});
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    chk({tag, " done"}, {30'd0, busy, done}, 32'd1);
    chk({tag, " out"}, {16'd0, out}, {16'd0, er});
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, eco});
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eov});
    hold_out = er;
    @(negedge clk);
    chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t        vecs[9];
  logic [15:0] mr;
  logic        mco, mov;
  int          n;

  initial begin
    reset = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; in1 = 16'h0; in2 = 16'h0;
    #2 reset = 1'b1;
    #1 chk("reset_async", {13'd0, busy, done, out, cout, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
             vecs[i].r, vecs[i].co, vecs[i].ov);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic rs, rc;
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      model(ra, rb, rs, rc, mr, mco, mov);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, rc, mr, mco, mov);
    end

    // start pulsed during RUN with new operands must be ignored
    @(negedge clk);
    in1 = 16'h0102; in2 = 16'h0304; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    in1 = 16'hAAAA; in2 = 16'h5555; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("ign_latency", n, 5);
    chk("ign_out", {16'd0, out}, 32'h0406);
    @(negedge clk);
    chk("ign_noqueue", {30'd0, busy, done}, 32'd0);
    hold_out = 16'h0406;

    // start held through DONE: back-to-back results five cycles apart
    @(negedge clk);
    in1 = 16'h1111; in2 = 16'h2222; sub = 1'b0; cin = 1'b1; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_lat", n, 5);
    chk("b2b_first_out", {16'd0, out}, 32'h3334);
    in1 = 16'h9000; in2 = 16'h0001; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart", {30'd0, busy, done}, 32'd2);
    n = 1;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_spacing", n, 5);
    chk("b2b_second_out", {16'd0, out}, 32'h8FFF);
    chk("b2b_second_cout", {31'd0, cout}, 32'd1);
    @(negedge clk);

    // reset while nibble 2 is in the adder
    @(negedge clk);
    in1 = 16'h4321; in2 = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_run", {13'd0, busy, done, out, cout, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("rst_no_done", n, 0);
    hold_out = 16'h0000;
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
